// File: rtl/slave_prueba2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slave_prueba2_pkg
// Purpose  : Shared constants, opcode and state encodings for the
//            Arduino-to-FPGA serial calculator slave.
// Contents : DATA_W, FRAME_BITS, CNT_W, IDX_W, opcode_e, state_t and the
//            state constants IDLE / WAIT_START / SHIFT / DONE.
// Revision : 1.0 - initial release
// ============================================================================
package slave_prueba2_pkg;

  // Width of each operand, operator and result field.
  localparam int DATA_W     = 4;
  // Payload bits after the handshake bit: op1, op2, opcode.
  localparam int FRAME_BITS = 3 * DATA_W;
  // Bit counter width; it only has to reach FRAME_BITS-1.
  localparam int CNT_W      = $clog2(FRAME_BITS);
  // Index width for selecting one bit of a DATA_W-wide field.
  localparam int IDX_W      = $clog2(DATA_W);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_AND = 4'b0001,
    OP_OR  = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SHL = 4'b0100,
    OP_SHR = 4'b0101,
    OP_MUL = 4'b0110,
    OP_SUB = 4'b1100
  } opcode_e;

  // Receiver state encoding, kept as plain constants so the encoding is fixed.
  typedef logic [1:0] state_t;
  localparam state_t IDLE       = 2'd0;
  localparam state_t WAIT_START = 2'd1;
  localparam state_t SHIFT      = 2'd2;
  localparam state_t DONE       = 2'd3;

endpackage : slave_prueba2_pkg
`default_nettype wire

// File: rtl/slave_prueba2_alu.sv
`default_nettype none
// ============================================================================
// Module   : alu_nibble
// Purpose  : Purely combinational DATA_W-bit ALU. Results wrap around and
//            no flags are produced. Unknown opcodes give zero.
// Ports    : op1, op2 [DATA_W] - operands
//            opcode  [DATA_W]   - operation select
//            result  [DATA_W]   - operation result
// Revision : 1.0 - initial release
// ============================================================================
module alu_nibble
  import slave_prueba2_pkg::*;
(
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD: result = op1 + op2;
      OP_AND: result = op1 & op2;
      OP_OR:  result = op1 | op2;
      OP_XOR: result = op1 ^ op2;
      // Shift amount uses only the two low bits of op2.
      OP_SHL: result = op1 << op2[1:0];
      OP_SHR: result = op1 >> op2[1:0];
      // Evaluated in DATA_W-bit context, so only the low product bits remain.
      OP_MUL: result = op1 * op2;
      OP_SUB: result = op1 - op2;
      default: result = '0;
    endcase
  end

endmodule : alu_nibble
`default_nettype wire

// File: rtl/slave_prueba2.sv
`default_nettype none
// ============================================================================
// Module   : slave_prueba2
// Purpose  : Serial slave of the Arduino calculator link. After CS falls it
//            waits for a '1' handshake bit, shifts in op1/op2/opcode
//            MSB-first, evaluates them and shows the result on the LEDs.
//            All state changes on the falling edge of the master clock.
// Ports    : clk_arduino - master serial clock (sampled on falling edge)
//            reset       - asynchronous, active-low reset
//            MOSI        - serial data from master, MSB-first
//            CS          - chip select, active-low (high = idle / abort)
//            MISO        - serial data to master
//            leds [DATA_W] - last computed result
// Options  : RESULT_TX_EN - when defined, the previous result is sent on
//            MISO MSB-first during the first DATA_W data bits of a frame;
//            otherwise MISO is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module slave_prueba2
  import slave_prueba2_pkg::*;
(
  input  logic              clk_arduino,
  input  logic              reset,
  input  logic              MOSI,
  input  logic              CS,
  output logic              MISO,
  output logic [DATA_W-1:0] leds
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  state_t                  state_q,  state_d;
  logic [FRAME_BITS-1:0]   shift_q,  shift_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  // Single register serves as both the LED value and the stored result
  // returned on MISO; the two are always identical.
  logic [DATA_W-1:0]       result_q, result_d;

  logic [FRAME_BITS-1:0]   word;
  logic [DATA_W-1:0]       alu_result;

  // Shift register contents including the bit sampled on this edge, so the
  // result can be latched on the same edge as the last data bit.
  assign word = {shift_q[FRAME_BITS-2:0], MOSI};

  alu_nibble u_alu (
    .op1    (word[3*DATA_W-1:2*DATA_W]),
    .op2    (word[2*DATA_W-1:DATA_W]),
    .opcode (word[DATA_W-1:0]),
    .result (alu_result)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (!CS) state_d = WAIT_START;
      end
      WAIT_START: begin
        if (CS) begin
          state_d = IDLE;
        end else if (MOSI) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (CS) begin
          // Abort: drop the partial word, keep the previous result.
          state_d = IDLE;
          shift_d = '0;
          cnt_d   = '0;
        end else begin
          shift_d = word;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            result_d = alu_result;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (CS) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk_arduino or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign leds = result_q;

`ifdef RESULT_TX_EN
  // Data bit k (counter == k) presents result[DATA_W-1-k] so the value is
  // stable across the falling edge that samples that bit.
  logic [CNT_W-1:0] tx_idx;
  assign tx_idx = CNT_W'(DATA_W - 1) - cnt_q;
  assign MISO   = (state_q == SHIFT && cnt_q < CNT_W'(DATA_W))
                  ? result_q[tx_idx[IDX_W-1:0]] : 1'b0;
`else
  assign MISO = 1'b0;
`endif

endmodule : slave_prueba2
`default_nettype wire

// File: tb/tb_slave_prueba2.sv
`default_nettype none
// ============================================================================
// Module   : tb_slave_prueba2
// Purpose  : Self-checking bench for slave_prueba2. Directed frames followed
//            by random frames, compared against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slave_prueba2;

  logic       clk_arduino = 1'b1;
  logic       reset       = 1'b1;
  logic       MOSI        = 1'b0;
  logic       CS          = 1'b1;
  wire        MISO;
  wire  [3:0] leds;

  int         tests   = 0;
  int         fails   = 0;
  logic [3:0] exp_res = 4'd0;

  slave_prueba2 dut (
    .clk_arduino (clk_arduino),
    .reset       (reset),
    .MOSI        (MOSI),
    .CS          (CS),
    .MISO        (MISO),
    .leds        (leds)
  );

  always #5 clk_arduino = ~clk_arduino;

  // Reference ALU written with plain integer arithmetic, wrapped modulo 16.
  function automatic logic [3:0] ref_alu(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a & b;
      2:       r = a | b;
      3:       r = a ^ b;
      4:       r = a * (1 << (b % 4));
      5:       r = a / (1 << (b % 4));
      6:       r = a * b;
      12:      r = a - b + 16;
      default: r = 0;
    endcase
    return 4'(r % 16);
  endfunction

  function automatic logic miso_exp(input int k);
`ifdef RESULT_TX_EN
    if (k < 4) begin
      logic [3:0] v;
      v = exp_res;
      return v[3-k];
    end
`endif
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive inputs just after the rising edge, then settle for sampling.
  task automatic tick(input logic cs, input logic mosi);
    @(posedge clk_arduino);
    CS   = cs;
    MOSI = mosi;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b0);
      check("miso_idle", {3'b0, MISO}, 4'd0);
    end
  endtask

  // One frame: CS low, optional leading zeros, handshake, 12 data bits,
  // optional trailing junk bits, then CS high. abort_at<12 raises CS early.
  task automatic frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                       input int lead, input int extra, input int abort_at);
    logic [11:0] w;
    logic [3:0]  old;
    w   = {a, b, op};
    old = exp_res;
    tick(1'b0, 1'b0);
    check("miso_cs", {3'b0, MISO}, 4'd0);
    for (int i = 0; i < lead; i++) begin
      tick(1'b0, 1'b0);
      check("miso_lead", {3'b0, MISO}, 4'd0);
    end
    tick(1'b0, 1'b1);
    check("miso_start", {3'b0, MISO}, 4'd0);
    for (int k = 0; k < 12; k++) begin
      if (k == abort_at) begin
        tick(1'b1, 1'b0);
        check("leds_abort", leds, old);
        tick(1'b1, 1'b0);
        check("leds_abort_idle", leds, old);
        check("miso_abort", {3'b0, MISO}, 4'd0);
        return;
      end
      tick(1'b0, w[11-k]);
      check("miso_tx", {3'b0, MISO}, {3'b0, miso_exp(k)});
      check("leds_hold", leds, old);
    end
    exp_res = ref_alu(int'(a), int'(b), int'(op));
    for (int i = 0; i < extra; i++) begin
      tick(1'b0, 1'($urandom % 2));
      check("leds_done", leds, exp_res);
      check("miso_done", {3'b0, MISO}, 4'd0);
    end
    tick(1'b1, 1'b0);
    check("leds_result", leds, exp_res);
    check("miso_end", {3'b0, MISO}, 4'd0);
  endtask

  initial begin
    int ops[9];
    int ab;
    logic [3:0] ra, rb, rop;

    // Reset low for 10 ns.
    #1 reset = 1'b0;
    #2;
    check("reset_leds", leds, 4'd0);
    check("reset_miso", {3'b0, MISO}, 4'd0);
    #8 reset = 1'b1;
    idle_cycles(2);

    // 1: SUB 12-6 = 6, nothing returned on MISO yet.
    frame(4'b1100, 4'b0110, 4'b1100, 0, 0, 99);
    check("t1_leds", leds, 4'b0110);

    // 2: idle gap, then a frame starting 1011; previous 0110 returned.
    idle_cycles(5);
    frame(4'b1011, 4'($urandom), 4'($urandom_range(0, 6)), 0, 1, 99);

    // 3: ADD wrap and MUL low bits.
    frame(4'b1111, 4'b0001, 4'b0000, 0, 0, 99);
    check("t3_add_wrap", leds, 4'b0000);
    frame(4'b0011, 4'b0101, 4'b0110, 0, 0, 99);
    check("t3_mul", leds, 4'b1111);

    // 4: aborted frame discarded, then a full XOR frame.
    frame(4'b0110, 4'b1001, 4'b0000, 0, 0, 6);
    frame(4'b0010, 4'b0001, 4'b0011, 0, 0, 99);
    check("t4_xor", leds, 4'b0011);

    // 5: leading zeros ignored; unknown opcode gives zero.
    frame(4'b0101, 4'b0011, 4'b0001, 3, 0, 99);
    check("t5_and", leds, 4'b0001);
    frame(4'b0111, 4'b0010, 4'b1111, 0, 2, 99);
    check("t5_badop", leds, 4'b0000);

    // Make the stored result nonzero before the reset test.
    frame(4'b1001, 4'b0100, 4'b0010, 0, 0, 99);

    // 6: reset mid-SHIFT clears outputs immediately.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'($urandom % 2));
    #1 reset = 1'b0;
    #1;
    check("t6_reset_leds", leds, 4'd0);
    check("t6_reset_miso", {3'b0, MISO}, 4'd0);
    exp_res = 4'd0;
    tick(1'b1, 1'b0);
    reset = 1'b1;
    idle_cycles(1);
    frame(4'b1010, 4'b0011, 4'b1100, 0, 0, 99);
    check("t6_after_reset", leds, 4'b0111);

    // Random frames.
    ops = '{0, 1, 2, 3, 4, 5, 6, 12, 15};
    for (int n = 0; n < 40; n++) begin
      ra  = 4'($urandom);
      rb  = 4'($urandom);
      rop = (n % 5 == 4) ? 4'($urandom) : 4'(ops[$urandom_range(0, 8)]);
      ab  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 11) : 99;
      frame(ra, rb, rop, $urandom_range(0, 2), $urandom_range(0, 2), ab);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_slave_prueba2
`default_nettype wire
